// File: rtl/bist_fail_log.sv
// bist_fail_log: logs BIST compare fails into a FWFT FIFO and keeps session status.
// Define BIST_FAIL_LOG_TS_EN to add a per-record cycle timestamp on rec_ts.
module bist_fail_log #(
  parameter int WCOUNT = 256,
  parameter int WLENGTH = 4,
  parameter int DEPTH = 8,
  parameter int CNTW = 12,
`ifdef BIST_FAIL_LOG_TS_EN
  parameter int TSW = 16,
`endif
  localparam int AW = $clog2(WCOUNT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tmode,
  input  logic               fail,
  input  logic [AW-1:0]      fail_addr,
  input  logic [WLENGTH-1:0] exp_data,
  input  logic [WLENGTH-1:0] act_data,
  output logic               rec_valid,
  input  logic               rec_ready,
  output logic [AW-1:0]      rec_addr,
  output logic [WLENGTH-1:0] rec_exp,
  output logic [WLENGTH-1:0] rec_act,
`ifdef BIST_FAIL_LOG_TS_EN
  output logic [TSW-1:0]     rec_ts,
`endif
  output logic [CNTW-1:0]    fail_cnt,
  output logic               first_vld,
  output logic [AW-1:0]      first_addr,
  output logic               overflow,
  output logic               done,
  output logic               pass
);
  localparam int PW = $clog2(DEPTH);
`ifdef BIST_FAIL_LOG_TS_EN
  localparam int RW = TSW + AW + 2 * WLENGTH;
`else
  localparam int RW = AW + 2 * WLENGTH;
`endif
  typedef enum logic [1:0] {IDLE, LOG, DONE} state_t;
  state_t state;
  logic tmode_q, rise, fall, clear, log, push, pop, fvld_b;
  logic [PW-1:0] wptr, rptr, wp, rp;
  logic [PW:0] count, cnt_b;
  logic [CNTW-1:0] fcnt_b;
  logic [RW-1:0] mem [DEPTH];
  logic [RW-1:0] rec_in;
`ifdef BIST_FAIL_LOG_TS_EN
  logic [TSW-1:0] ts, ts_b;
  assign ts_b = clear ? '0 : ts;
  assign rec_in = {ts_b, fail_addr, exp_data, act_data};
  assign {rec_ts, rec_addr, rec_exp, rec_act} = mem[rptr];
  always_ff @(posedge clk)
    ts <= rst ? '0 : ts_b + TSW'(clear | (state == LOG));
`else
  assign rec_in = {fail_addr, exp_data, act_data};
  assign {rec_addr, rec_exp, rec_act} = mem[rptr];
`endif
  assign rec_valid = count != '0;
  // A rise starts a fresh session: every "_b" value is the state as seen after the clear.
  always_comb begin
    rise = tmode & ~tmode_q;
    fall = ~tmode & tmode_q;
    clear = rise & (state != LOG);
    log = fail & tmode & ((state == LOG) | rise);
    cnt_b = clear ? '0 : count;
    wp = clear ? '0 : wptr;
    rp = clear ? '0 : rptr;
    fcnt_b = clear ? '0 : fail_cnt;
    fvld_b = clear ? 1'b0 : first_vld;
    pop = rec_valid & rec_ready & ~clear;
    push = log & ((cnt_b != (PW+1)'(DEPTH)) | pop);
  end
  always_ff @(posedge clk)
    if (push) mem[wp] <= rec_in;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tmode_q <= 1'b0;
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      fail_cnt <= '0;
      first_vld <= 1'b0;
      first_addr <= '0;
      overflow <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
    end else begin
      tmode_q <= tmode;
      state <= clear ? LOG : (fall && state == LOG) ? DONE : state;
      wptr <= wp + PW'(push);
      rptr <= rp + PW'(pop);
      count <= cnt_b + (PW+1)'(push) - (PW+1)'(pop);
      fail_cnt <= fcnt_b + CNTW'(log & ~(&fcnt_b));
      first_vld <= fvld_b | log;
      if (log & ~fvld_b) first_addr <= fail_addr;
      overflow <= (clear ? 1'b0 : overflow) | (log & ~push);
      done <= fall;
      pass <= clear ? 1'b0 : fall ? (fail_cnt == '0) : pass;
    end
  end
endmodule

// File: tb/tb_bist_fail_log.sv
// tb_bist_fail_log: directed scenario tasks for bist_fail_log with hand-computed expectations.
module tb_bist_fail_log;
  logic clk = 1'b0;
  logic rst, tmode, fail, rec_ready;
  logic [7:0] fail_addr, rec_addr, first_addr;
  logic [3:0] exp_data, act_data, rec_exp, rec_act;
  logic [11:0] fail_cnt;
  logic rec_valid, first_vld, overflow, done, pass;
`ifdef BIST_FAIL_LOG_TS_EN
  logic [15:0] rec_ts;
`endif
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bist_fail_log dut (
    .clk(clk), .rst(rst), .tmode(tmode), .fail(fail), .fail_addr(fail_addr),
    .exp_data(exp_data), .act_data(act_data), .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_addr(rec_addr), .rec_exp(rec_exp), .rec_act(rec_act),
`ifdef BIST_FAIL_LOG_TS_EN
    .rec_ts(rec_ts),
`endif
    .fail_cnt(fail_cnt), .first_vld(first_vld), .first_addr(first_addr),
    .overflow(overflow), .done(done), .pass(pass)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; tmode = 0; fail = 0; rec_ready = 0; fail_addr = 0; exp_data = 0; act_data = 0;
    cyc(); cyc();
    rst = 0;
    n_cmp++; if (rec_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", rec_valid); end
    n_cmp++; if (fail_cnt !== 12'd0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", fail_cnt); end
    n_cmp++; if (first_vld !== 1'b0 || first_addr !== 8'h00) begin n_err++; $display("FAIL reset_first got %b/%h want 0/00", first_vld, first_addr); end
    n_cmp++; if (overflow !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin n_err++; $display("FAIL reset_status got ovf=%b done=%b pass=%b want 0/0/0", overflow, done, pass); end
  endtask

  task automatic test_basic();
    tmode = 1; rec_ready = 1; fail = 0;
    cyc();
    n_cmp++; if (rec_valid !== 1'b0) begin n_err++; $display("FAIL basic_rise_valid got %b want 0", rec_valid); end
    fail = 1; fail_addr = 8'h05; exp_data = 4'h5; act_data = 4'h4;
    cyc();
    n_cmp++; if (rec_valid !== 1'b1 || rec_addr !== 8'h05) begin n_err++; $display("FAIL basic_rec0 got v=%b a=%h want 1/05", rec_valid, rec_addr); end
    n_cmp++; if (rec_exp !== 4'h5 || rec_act !== 4'h4) begin n_err++; $display("FAIL basic_data got %h/%h want 5/4", rec_exp, rec_act); end
    n_cmp++; if (first_vld !== 1'b1 || first_addr !== 8'h05 || fail_cnt !== 12'd1) begin n_err++; $display("FAIL basic_first got %b/%h cnt=%0d want 1/05 cnt=1", first_vld, first_addr, fail_cnt); end
    fail_addr = 8'h3A;
    cyc();
    n_cmp++; if (rec_valid !== 1'b1 || rec_addr !== 8'h3A) begin n_err++; $display("FAIL basic_rec1 got v=%b a=%h want 1/3a", rec_valid, rec_addr); end
    n_cmp++; if (fail_cnt !== 12'd2 || first_addr !== 8'h05) begin n_err++; $display("FAIL basic_cnt got %0d/%h want 2/05", fail_cnt, first_addr); end
    fail = 0;
    cyc();
    n_cmp++; if (rec_valid !== 1'b0) begin n_err++; $display("FAIL basic_drained got %b want 0", rec_valid); end
    tmode = 0;
    cyc();
    n_cmp++; if (done !== 1'b1 || pass !== 1'b0 || fail_cnt !== 12'd2) begin n_err++; $display("FAIL basic_end got done=%b pass=%b cnt=%0d want 1/0/2", done, pass, fail_cnt); end
    cyc();
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL basic_done_pulse got %b want 0", done); end
  endtask

  task automatic test_no_fail();
    tmode = 1; rec_ready = 1; fail = 0;
    repeat (40) cyc();
    n_cmp++; if (first_vld !== 1'b0 || fail_cnt !== 12'd0) begin n_err++; $display("FAIL nofail_clear got vld=%b cnt=%0d want 0/0", first_vld, fail_cnt); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL nofail_early_done got %b want 0", done); end
    tmode = 0;
    cyc();
    n_cmp++; if (done !== 1'b1 || pass !== 1'b1 || rec_valid !== 1'b0) begin n_err++; $display("FAIL nofail_end got done=%b pass=%b v=%b want 1/1/0", done, pass, rec_valid); end
    cyc();
    n_cmp++; if (done !== 1'b0 || pass !== 1'b1) begin n_err++; $display("FAIL nofail_hold got done=%b pass=%b want 0/1", done, pass); end
  endtask

  task automatic test_overflow();
    tmode = 1; rec_ready = 0; fail = 0;
    cyc();
    fail = 1; exp_data = 4'hA; act_data = 4'hB;
    for (int i = 0; i < 10; i++) begin
      fail_addr = 8'(32 + i);
      cyc();
      if (i == 7) begin
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_at_full got %b want 0", overflow); end
      end
    end
    fail = 0;
    n_cmp++; if (overflow !== 1'b1 || fail_cnt !== 12'd10) begin n_err++; $display("FAIL ovf_status got ovf=%b cnt=%0d want 1/10", overflow, fail_cnt); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (rec_valid !== 1'b1 || rec_addr !== 8'(32 + i)) begin n_err++; $display("FAIL ovf_drain%0d got v=%b a=%h want 1/%h", i, rec_valid, rec_addr, 8'(32 + i)); end
      rec_ready = 1;
      cyc();
    end
    rec_ready = 0;
    n_cmp++; if (rec_valid !== 1'b0) begin n_err++; $display("FAIL ovf_drain_end got %b want 0", rec_valid); end
    tmode = 0;
    cyc();
    n_cmp++; if (done !== 1'b1 || pass !== 1'b0) begin n_err++; $display("FAIL ovf_end got done=%b pass=%b want 1/0", done, pass); end
  endtask

  task automatic test_back_to_back();
    tmode = 1; rec_ready = 0; fail = 0;
    cyc();
    fail = 1;
    for (int i = 0; i < 8; i++) begin
      fail_addr = 8'(64 + i);
      cyc();
    end
    n_cmp++; if (overflow !== 1'b0 || fail_cnt !== 12'd8 || rec_addr !== 8'h40) begin n_err++; $display("FAIL b2b_fill got ovf=%b cnt=%0d a=%h want 0/8/40", overflow, fail_cnt, rec_addr); end
    rec_ready = 1;
    for (int i = 0; i < 5; i++) begin
      fail_addr = 8'(72 + i);
      cyc();
      n_cmp++; if (overflow !== 1'b0 || rec_addr !== 8'(65 + i)) begin n_err++; $display("FAIL b2b_step%0d got ovf=%b a=%h want 0/%h", i, overflow, rec_addr, 8'(65 + i)); end
    end
    fail = 0;
    n_cmp++; if (fail_cnt !== 12'd13) begin n_err++; $display("FAIL b2b_cnt got %0d want 13", fail_cnt); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (rec_valid !== 1'b1 || rec_addr !== 8'(69 + i)) begin n_err++; $display("FAIL b2b_drain%0d got v=%b a=%h want 1/%h", i, rec_valid, rec_addr, 8'(69 + i)); end
      cyc();
    end
    n_cmp++; if (rec_valid !== 1'b0) begin n_err++; $display("FAIL b2b_occupancy got v=%b want 0", rec_valid); end
    rec_ready = 0; tmode = 0;
    cyc();
  endtask

  task automatic test_session_clear();
    tmode = 1; rec_ready = 0; fail = 0;
    cyc();
    fail = 1;
    for (int i = 0; i < 3; i++) begin
      fail_addr = 8'(96 + i);
      cyc();
    end
    fail = 0; tmode = 0;
    cyc();
    n_cmp++; if (done !== 1'b1 || rec_valid !== 1'b1) begin n_err++; $display("FAIL clr_s1_end got done=%b v=%b want 1/1", done, rec_valid); end
    cyc();
    tmode = 1; fail = 1; fail_addr = 8'h11; rec_ready = 1;
    cyc();
    n_cmp++; if (rec_valid !== 1'b1 || rec_addr !== 8'h11) begin n_err++; $display("FAIL clr_head got v=%b a=%h want 1/11", rec_valid, rec_addr); end
    n_cmp++; if (fail_cnt !== 12'd1 || first_addr !== 8'h11 || overflow !== 1'b0) begin n_err++; $display("FAIL clr_status got cnt=%0d first=%h ovf=%b want 1/11/0", fail_cnt, first_addr, overflow); end
    fail = 0;
    cyc();
    n_cmp++; if (rec_valid !== 1'b0) begin n_err++; $display("FAIL clr_single got v=%b want 0", rec_valid); end
    rec_ready = 0;
  endtask

  task automatic test_reset_mid();
    fail = 1;
    for (int i = 0; i < 4; i++) begin
      fail_addr = 8'(112 + i);
      cyc();
    end
    fail = 0;
    n_cmp++; if (rec_valid !== 1'b1 || fail_cnt !== 12'd5) begin n_err++; $display("FAIL rmid_pre got v=%b cnt=%0d want 1/5", rec_valid, fail_cnt); end
    rst = 1; tmode = 0;
    cyc();
    n_cmp++; if (rec_valid !== 1'b0 || fail_cnt !== 12'd0 || first_vld !== 1'b0) begin n_err++; $display("FAIL rmid_rst got v=%b cnt=%0d fv=%b want 0/0/0", rec_valid, fail_cnt, first_vld); end
    rst = 0; fail = 1; fail_addr = 8'h7F;
    repeat (3) cyc();
    n_cmp++; if (rec_valid !== 1'b0 || fail_cnt !== 12'd0 || done !== 1'b0) begin n_err++; $display("FAIL rmid_idle got v=%b cnt=%0d done=%b want 0/0/0", rec_valid, fail_cnt, done); end
    fail = 0; tmode = 1;
    cyc();
    tmode = 0;
    cyc();
    n_cmp++; if (done !== 1'b1 || pass !== 1'b1) begin n_err++; $display("FAIL rmid_session got done=%b pass=%b want 1/1", done, pass); end
  endtask

  task automatic test_saturate();
    tmode = 1; rec_ready = 0; fail = 0;
    cyc();
    fail = 1; fail_addr = 8'h99;
    repeat (4100) cyc();
    fail = 0;
    n_cmp++; if (fail_cnt !== 12'hFFF || overflow !== 1'b1) begin n_err++; $display("FAIL sat_cnt got %h ovf=%b want fff/1", fail_cnt, overflow); end
    n_cmp++; if (rec_addr !== 8'h99 || first_addr !== 8'h99) begin n_err++; $display("FAIL sat_addr got %h/%h want 99/99", rec_addr, first_addr); end
    tmode = 0;
    cyc();
    n_cmp++; if (done !== 1'b1 || pass !== 1'b0) begin n_err++; $display("FAIL sat_end got done=%b pass=%b want 1/0", done, pass); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_no_fail();
    test_overflow();
    test_back_to_back();
    test_session_clear();
    test_reset_mid();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
